// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// One shift-add or restoring shift-subtract step per clock, then a sign-fix cycle.
module hilo_muldiv_unit #(
   parameter int         WIDTH    = 32,
   parameter logic [1:0] OP_MULT  = 2'b00,
   parameter logic [1:0] OP_MULTU = 2'b01,
   parameter logic [1:0] OP_DIV   = 2'b10,
   parameter logic [1:0] OP_DIVU  = 2'b11
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int              CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state, state_nxt;
   logic               accept;
   logic               op_div, op_signed, b_zero;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [CNT_W-1:0]   count;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd_b;
   logic               is_div, neg_res, neg_rem, zero_div;

   assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
   assign op_signed = (op == OP_MULT) || (op == OP_DIV);
   assign b_zero    = (src_b == '0);
   assign abs_a     = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
   assign abs_b     = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;
   assign busy      = (state != IDLE);

   // Multiply step: acc = {partial product, remaining multiplier bits}.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_step;
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd_b : {WIDTH{1'b0}})};
   assign mul_step = {mul_sum, acc[WIDTH-1:1]};

   // Divide step: acc = {partial remainder, dividend bits shifting into quotient}.
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH+1:0]   div_diff;
   logic               fits;
   logic [WIDTH-1:0]   new_rem;
   logic [2*WIDTH-1:0] div_step;
   assign rem_shift = acc[2*WIDTH-1:WIDTH-1];
   assign div_diff  = {1'b0, rem_shift} - {2'b00, opnd_b};
   assign fits      = ~div_diff[WIDTH+1];
   assign new_rem   = fits ? div_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
   assign div_step  = {new_rem, acc[WIDTH-2:0], fits};

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;
   assign prod_fix = neg_res ? -acc : acc;
   assign quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first so no path holds a stale value (no latch).
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: if (start && !flush) begin
            accept    = 1'b1;
            state_nxt = (op_div && b_zero) ? FIX : CALC;
         end
         CALC: if (flush)              state_nxt = IDLE;
               else if (count == LAST) state_nxt = FIX;
         FIX:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count    <= '0;
         acc      <= '0;
         opnd_b   <= '0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         zero_div <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         if (accept) begin
            count    <= '0;
            acc      <= {{WIDTH{1'b0}}, abs_a};
            opnd_b   <= abs_b;
            is_div   <= op_div;
            neg_res  <= op_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_rem  <= op_signed && src_a[WIDTH-1];
            zero_div <= op_div && b_zero;
         end else if (state == CALC && !flush) begin
            count <= count + CNT_W'(1);
            acc   <= is_div ? div_step : mul_step;
         end else if (state == FIX && !flush) begin
            done <= 1'b1;
            if (zero_div)    div_zero <= 1'b1;
            else if (is_div) {hi, lo} <= {rem_fix, quot_fix};
            else             {hi, lo} <= prod_fix;
         end else if (state == IDLE && !flush) begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
         end
      end
   end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed corner cases plus random
// operations against an arithmetic reference model.
module tb_hilo_muldiv_unit;

   logic        clock, reset, start, mthi, mtlo, flush;
   logic [1:0]  op;
   logic [31:0] src_a, src_b, wdata;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] m_hi  = '0;
   logic [31:0] m_lo  = '0;

   hilo_muldiv_unit dut (
      .clock(clock), .reset(reset), .start(start), .op(op),
      .src_a(src_a), .src_b(src_b), .mthi(mthi), .mtlo(mtlo),
      .wdata(wdata), .flush(flush), .busy(busy), .done(done),
      .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic; SV division truncates toward zero and
   // the remainder takes the dividend's sign, matching the architecture.
   function automatic void model(input logic [1:0] o, input logic [31:0] a, b,
                                 input logic [31:0] ch, cl,
                                 output logic [31:0] eh, el, output bit dz);
      longint      sa, sb;
      logic [63:0] r;
      eh = ch; el = cl; dz = 0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         2'b00: begin r = 64'(sa * sb); {eh, el} = r; end
         2'b01: begin r = {32'd0, a} * {32'd0, b}; {eh, el} = r; end
         2'b10: if (b == 0) dz = 1;
                else begin r = 64'(sa / sb); el = r[31:0]; r = 64'(sa % sb); eh = r[31:0]; end
         default: if (b == 0) dz = 1;
                  else begin el = a / b; eh = a % b; end
      endcase
   endfunction

   task automatic do_op(input logic [1:0] o, input logic [31:0] a, b, input bit poke);
      logic [31:0] eh, el;
      bit          edz, busy_ok;
      int          n;
      model(o, a, b, m_hi, m_lo, eh, el, edz);
      @(negedge clock);
      start = 1; op = o; src_a = a; src_b = b;
      @(negedge clock);
      start = 0; n = 1; busy_ok = 1;
      while (!done && n < 60) begin
         if (!busy) busy_ok = 0;
         if (poke && n == 5) begin
            start = 1; src_a = ~a; src_b = 32'd3; mtlo = 1; wdata = 32'hDEAD_BEEF;
         end else begin
            start = 0; mtlo = 0;
         end
         @(negedge clock);
         n++;
      end
      start = 0; mtlo = 0;
      check("busy_hold", 64'(busy_ok), 64'd1);
      check("latency", 64'(n), edz ? 64'd2 : 64'd34);
      check("hi", 64'(hi), 64'(eh));
      check("lo", 64'(lo), 64'(el));
      check("div_zero", 64'(div_zero), 64'(edz));
      check("busy_at_done", 64'(busy), 64'd0);
      m_hi = eh; m_lo = el;
      @(negedge clock);
      check("done_pulse", 64'(done), 64'd0);
      check("dz_pulse", 64'(div_zero), 64'd0);
   endtask

   initial begin
      int n;
      bit saw_done;
      logic [1:0]  ro;
      logic [31:0] ra, rb;

      reset = 0; start = 0; op = 0; src_a = 0; src_b = 0;
      mthi = 0; mtlo = 0; wdata = 0; flush = 0;
      #12;
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_dz", 64'(div_zero), 64'd0);
      @(negedge clock); reset = 1;

      // Directed arithmetic corner cases.
      do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1);
      do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
      do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
      do_op(2'b11, 32'd7, 32'd2, 0);
      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      check("div_ovf_lo", 64'(lo), 64'h8000_0000);

      // MTHI/MTLO writes in IDLE.
      @(negedge clock); mthi = 1; wdata = 32'h0000_ABCD;
      @(negedge clock); mthi = 0;
      check("mthi", 64'(hi), 64'h0000_ABCD);
      mthi = 1; mtlo = 1; wdata = 32'h11;
      @(negedge clock); mthi = 0; mtlo = 1; wdata = 32'h22;
      @(negedge clock); mtlo = 0;
      check("mt_hi", 64'(hi), 64'h11);
      check("mt_lo", 64'(lo), 64'h22);
      m_hi = 32'h11; m_lo = 32'h22;
      do_op(2'b11, 32'd5, 32'd0, 0);

      // Accepted start with simultaneous MTHI: the write is dropped.
      start = 1; op = 2'b11; src_a = 32'd9; src_b = 32'd0; mthi = 1; wdata = 32'h55;
      @(negedge clock); start = 0; mthi = 0;
      check("start_busy", 64'(busy), 64'd1);
      @(negedge clock);
      check("mthi_drop_done", 64'(done), 64'd1);
      check("mthi_drop_hi", 64'(hi), 64'(m_hi));

      // Flush mid-multiply with an MTLO while busy; both must leave HI/LO intact.
      @(negedge clock);
      start = 1; op = 2'b00; src_a = 32'd6; src_b = 32'd7;
      saw_done = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clock);
         start = 0;
         if (done) saw_done = 1;
         mtlo  = (i == 3);
         wdata = 32'hDEAD;
         flush = (i == 10);
      end
      @(negedge clock); flush = 0;
      if (done) saw_done = 1;
      check("flush_busy", 64'(busy), 64'd0);
      check("flush_nodone", 64'(saw_done), 64'd0);
      check("flush_hi", 64'(hi), 64'(m_hi));
      check("flush_lo", 64'(lo), 64'(m_lo));
      start = 1; op = 2'b01; src_a = 32'd3; src_b = 32'd4;
      @(negedge clock); start = 0;
      check("restart_busy", 64'(busy), 64'd1);
      n = 1;
      while (!done && n < 60) begin @(negedge clock); n++; end
      check("restart_lat", 64'(n), 64'd34);
      check("restart_lo", 64'(lo), 64'd12);
      check("restart_hi", 64'(hi), 64'd0);
      m_hi = 0; m_lo = 12;

      // Flush together with start in IDLE: not accepted.
      @(negedge clock); start = 1; flush = 1; op = 2'b00;
      @(negedge clock); start = 0; flush = 0;
      check("flush_start", 64'(busy), 64'd0);

      // Asynchronous reset mid-divide.
      start = 1; op = 2'b10; src_a = 32'd100; src_b = 32'd7;
      @(negedge clock); start = 0;
      repeat (5) @(negedge clock);
      #1 reset = 0;
      #2;
      check("rst_mid_hi", 64'(hi), 64'd0);
      check("rst_mid_lo", 64'(lo), 64'd0);
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_done", 64'(done), 64'd0);
      m_hi = 0; m_lo = 0;
      @(negedge clock); reset = 1;

      // Random operations against the reference model.
      for (int k = 0; k < 24; k++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 9));
            2: ra = 32'h8000_0000;
            default: ;
         endcase
         do_op(ro, ra, rb, k[0]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
